// File: rtl/stream_demux2_pkg.sv
// Shared constants and types for the 20-bit one-to-two stream steering block.
package stream_demux2_pkg;

    localparam int DATA_W = 20;

    localparam logic DEST_A = 1'b0;
    localparam logic DEST_B = 1'b1;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid flag, load/drain control and drain counter.
import stream_demux2_pkg::*;

module demux_slot #(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             can_load,
    output logic [CNT_W-1:0] count
);

    slot_state_t state_q;
    slot_state_t state_d;
    logic        drain;

    assign valid    = (state_q == SLOT_FULL);
    assign drain    = valid && ready;
    assign can_load = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (load) state_d = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    // wraps naturally modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (drain) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stream_demux2.sv
// Steers one valid/ready stream to slot A or B, by select bit or round-robin.
import stream_demux2_pkg::*;

module stream_demux2 #(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sel,
    output logic             in_ready,
    input  logic             mode,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             next_dest,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic dest;
    logic accept;
    logic a_can_load;
    logic b_can_load;
    logic a_load;
    logic b_load;

    assign dest     = (mode == MODE_RR) ? next_dest : in_sel;
    assign in_ready = (dest == DEST_B) ? b_can_load : a_can_load;
    assign accept   = in_valid && in_ready;
    assign a_load   = accept && (dest == DEST_A);
    assign b_load   = accept && (dest == DEST_B);

    // pointer survives mode changes; only moves on round-robin accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_dest <= DEST_A;
        end else if (accept && (mode == MODE_RR)) begin
            next_dest <= ~next_dest;
        end
    end

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (a_load),
        .load_data (in_data),
        .ready     (a_ready),
        .data      (a_data),
        .valid     (a_valid),
        .can_load  (a_can_load),
        .count     (a_count)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (b_load),
        .load_data (in_data),
        .ready     (b_ready),
        .data      (b_data),
        .valid     (b_valid),
        .can_load  (b_can_load),
        .count     (b_count)
    );

endmodule
